// File: rtl/latch_sequencer.sv
// Command sequencer for the 12-bit dual-bank latch block: turns single-word
// commands into edge-clean load strobes and non-overlapping output enables.
module latch_sequencer #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_op,
   output logic       cmd_ready,
   output logic       busy,
   output logic       done,
   output logic       lat_setvalue,
   output logic       lat_latch,
   output logic       lat_latch3,
   output logic       lat_oe1,
   output logic       lat_oe2,
   output logic       lat_oe3
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_PULSE = 3'd2;
   localparam logic [2:0] S_RELAX = 3'd3;
   localparam logic [2:0] S_DRIVE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_LD3  = 3'd2;
   localparam logic [2:0] OP_SET  = 3'd3;
   localparam logic [2:0] OP_RD1  = 3'd4;
   localparam logic [2:0] OP_RD2  = 3'd5;
   localparam logic [2:0] OP_RD3  = 3'd6;
   localparam logic [2:0] OP_LDRD = 3'd7;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [2:0]       state, state_nxt;
   logic [2:0]       op, op_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_comb begin
      state_nxt = state;
      op_nxt    = op;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               op_nxt = cmd_op;
               case (cmd_op)
                  OP_NOP: state_nxt = S_DONE;
                  OP_RD1, OP_RD2, OP_RD3: begin
                     state_nxt = S_DRIVE;
                     cnt_nxt   = HOLD_LOAD;
                  end
                  default: state_nxt = S_SETUP;
               endcase
            end
         end
         S_SETUP: state_nxt = S_PULSE;
         S_PULSE: state_nxt = S_RELAX;
         S_RELAX: begin
            if (op == OP_LDRD) begin
               state_nxt = S_DRIVE;
               cnt_nxt   = HOLD_LOAD;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_DRIVE: begin
            if (cnt == '0) state_nxt = S_DONE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every strobe is a flop output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         op           <= OP_NOP;
         cnt          <= '0;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         lat_setvalue <= 1'b0;
         lat_latch    <= 1'b0;
         lat_latch3   <= 1'b0;
         lat_oe1      <= 1'b0;
         lat_oe2      <= 1'b0;
         lat_oe3      <= 1'b0;
      end else begin
         state        <= state_nxt;
         op           <= op_nxt;
         cnt          <= cnt_nxt;
         cmd_ready    <= (state_nxt == S_IDLE);
         busy         <= (state_nxt != S_IDLE);
         done         <= (state_nxt == S_DONE);
         lat_setvalue <= ((state_nxt == S_SETUP) || (state_nxt == S_PULSE)) && (op_nxt == OP_SET);
         lat_latch    <= (state_nxt == S_PULSE) &&
                         ((op_nxt == OP_LD) || (op_nxt == OP_SET) || (op_nxt == OP_LDRD));
         lat_latch3   <= (state_nxt == S_PULSE) && (op_nxt == OP_LD3);
         lat_oe1      <= (state_nxt == S_DRIVE) && ((op_nxt == OP_RD1) || (op_nxt == OP_LDRD));
         lat_oe2      <= (state_nxt == S_DRIVE) && (op_nxt == OP_RD2);
         lat_oe3      <= (state_nxt == S_DRIVE) && (op_nxt == OP_RD3);
      end
   end

endmodule

// File: tb/tb_latch_sequencer.sv
// Bench for latch_sequencer: per-cycle expected output vectors are queued as
// stimulus is driven and compared against the DUT one cycle later.
module tb_latch_sequencer;

   localparam int unsigned HOLD = 3;

   typedef logic [8:0] vec_t;  // ready busy done setv latch latch3 oe1 oe2 oe3
   localparam vec_t IDLE_V = 9'b1_0000_0000;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic       cmd_ready, busy, done;
   logic       lat_setvalue, lat_latch, lat_latch3;
   logic       lat_oe1, lat_oe2, lat_oe3;

   always #5 clk = ~clk;

   latch_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_op       (cmd_op),
      .cmd_ready    (cmd_ready),
      .busy         (busy),
      .done         (done),
      .lat_setvalue (lat_setvalue),
      .lat_latch    (lat_latch),
      .lat_latch3   (lat_latch3),
      .lat_oe1      (lat_oe1),
      .lat_oe2      (lat_oe2),
      .lat_oe3      (lat_oe3)
   );

   vec_t  sb[$];
   string sb_tag[$];
   vec_t  trace[$];
   vec_t  cur = IDLE_V;
   string cur_name = "idle";
   int    errors = 0;
   int    checks = 0;
   logic  prev_strobe = 1'b0;

   task automatic check(input string tag, input vec_t got, input vec_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic d, input logic sv, input logic lt, input logic lt3,
                               input logic o1, input logic o2, input logic o3);
      return {1'b0, 1'b1, d, sv, lt, lt3, o1, o2, o3};
   endfunction

   // Expected outputs for each cycle after accept, ending with the done cycle.
   task automatic build(input logic [2:0] op);
      logic sv, lt;
      trace.delete();
      if (op == 3'd0) begin
         trace.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      end else if (op >= 3'd4 && op <= 3'd6) begin
         for (int unsigned i = 0; i < HOLD; i++)
            trace.push_back(mk(0, 0, 0, 0, op == 3'd4, op == 3'd5, op == 3'd6));
         trace.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      end else begin
         sv = (op == 3'd3);
         lt = (op != 3'd2);
         trace.push_back(mk(0, sv, 0, 0, 0, 0, 0));
         trace.push_back(mk(0, sv, lt, !lt, 0, 0, 0));
         trace.push_back(mk(0, 0, 0, 0, 0, 0, 0));
         if (op == 3'd7)
            for (int unsigned i = 0; i < HOLD; i++)
               trace.push_back(mk(0, 0, 0, 0, 1, 0, 0));
         trace.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic r, input string name);
      cmd_valid = v;
      cmd_op    = op;
      reset     = r;
      if (r) begin
         trace.delete();
         cur = IDLE_V;
      end else if (trace.size() == 0) begin
         if (cur[8] && v) begin
            build(op);
            cur_name = $sformatf("%s_op%0d", name, op);
            cur = trace.pop_front();
         end else begin
            cur = IDLE_V;
         end
      end else begin
         cur = trace.pop_front();
      end
      sb.push_back(cur);
      sb_tag.push_back(r ? "reset" : (cur == IDLE_V ? "idle" : cur_name));
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      vec_t  e;
      string t;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         t = sb_tag.pop_front();
         check(t, {cmd_ready, busy, done, lat_setvalue, lat_latch, lat_latch3,
                   lat_oe1, lat_oe2, lat_oe3}, e);
         check("inv_oe_onehot", 9'($countones({lat_oe1, lat_oe2, lat_oe3}) > 1), 9'd0);
         check("inv_oe_vs_strobe",
               9'((lat_oe1 | lat_oe2 | lat_oe3) & (lat_latch | lat_latch3)), 9'd0);
         check("inv_strobe_excl", 9'(lat_latch & lat_latch3), 9'd0);
         check("inv_strobe_consec", 9'(prev_strobe & (lat_latch | lat_latch3)), 9'd0);
         prev_strobe = lat_latch | lat_latch3;
      end
   end

   initial begin
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      reset     = 1'b1;
      drive(0, 0, 1, "rst");
      drive(0, 0, 1, "rst");
      drive(0, 0, 0, "idle");

      // single commands, each followed by enough idle cycles to complete
      for (int unsigned k = 0; k < 8; k++) begin
         drive(1, 3'(k), 0, "single");
         repeat (HOLD + 6) drive(0, 0, 0, "idle");
      end

      // op changes while busy are ignored; valid held high re-accepts in IDLE
      drive(1, 2, 0, "chg");
      drive(1, 5, 0, "chg");
      drive(1, 6, 0, "chg");
      repeat (6) drive(1, 5, 0, "chg");
      repeat (HOLD + 4) drive(0, 0, 0, "idle");

      // back-to-back LD with valid held
      repeat (12) drive(1, 1, 0, "b2b");
      repeat (6) drive(0, 0, 0, "idle");

      // reset while LD3 is in PULSE, then a normal RD3
      drive(1, 2, 0, "ld3rst");
      drive(0, 0, 0, "ld3rst");
      drive(0, 0, 1, "ld3rst");
      drive(0, 0, 0, "idle");
      drive(1, 6, 0, "rd3after");
      repeat (HOLD + 3) drive(0, 0, 0, "idle");

      // random traffic with occasional reset
      repeat (300)
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 40) == 0), "rnd");

      drive(0, 0, 1, "rst");
      drive(0, 0, 0, "idle");
      @(posedge clk);
      #2;
      check("sb_drain", 9'(sb.size()), 9'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
